mem_data_unit: RTL and testbench

- Memory-stage (M) data path for the P5 pipeline: narrows and aligns store data, generates byte enables, and widens/extends load data returned by the synchronous data memory.
- Performs the reverse of the D-stage immediate extender (32-bit to sub-word lanes on stores), plus its load-side counterpart (sub-word lanes to 32-bit on loads).
- Sits between the M-stage ALU result and store-data forwarding mux on one side, and the data memory and W-stage result mux on the other.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/load_ext.sv | 34 +++
 rtl/mem_data_unit.sv | 83 ++++++++
 tb/tb_mem_data_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the M-stage data path: memory-op encoding, lane
// enables and the load context carried from M to W.
package mem_pkg;

  typedef enum logic [2:0] {
    MEM_NONE = 3'd0,
    MEM_SW   = 3'd1,
    MEM_SH   = 3'd2,
    MEM_SB   = 3'd3,
    MEM_LW   = 3'd4,
    MEM_LH   = 3'd5,
    MEM_LHU  = 3'd6,
    MEM_LB   = 3'd7
  } mem_op_e;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_BYTE = 4'b0001;

  typedef struct packed {
    logic       valid;
    logic [1:0] off;
    mem_op_e    op;
    logic       sgn;
  } ld_ctx_t;

endpackage

// File: rtl/load_ext.sv
// Load-side lane select and sign/zero extension of the DM read word.
// Purely combinational; zero output when no load is in flight.
module load_ext
  import mem_pkg::*;
(
  input  ld_ctx_t     ctx_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ldata_o
);

  logic [15:0] half;
  logic [7:0]  byte_sel;

  always_comb begin
    half = ctx_i.off[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (ctx_i.off)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase

    ldata_o = '0;
    if (ctx_i.valid) begin
      case (ctx_i.op)
        MEM_LW:          ldata_o = rdata_i;
        MEM_LH, MEM_LHU: ldata_o = {{16{ctx_i.sgn & half[15]}}, half};
        MEM_LB:          ldata_o = {{24{ctx_i.sgn & byte_sel[7]}}, byte_sel};
        default:         ldata_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/mem_data_unit.sv
// M-stage data path: store lane alignment/byte enables, load request and a
// held M-to-W load context; load data reaches W one cycle after issue.
module mem_data_unit
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] M_addr,
  input  logic [DATA_W-1:0] M_wdata,
  input  logic [OP_W-1:0]   M_memop,
  input  logic              M_lbu,
  input  logic              M_hold,
  output logic [DATA_W-1:0] m_data_addr,
  output logic [3:0]        m_data_byteen,
  output logic [DATA_W-1:0] m_data_wdata,
  output logic              m_data_re,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic [DATA_W-1:0] W_ldata,
  output logic              W_lvalid,
  output logic              M_align_err
);

  ld_ctx_t ctx_q, ctx_d;

  assign m_data_addr = {M_addr[DATA_W-1:2], 2'b00};

  // Misaligned accesses raise the error and suppress both write and read.
  always_comb begin
    m_data_byteen = '0;
    m_data_wdata  = M_wdata;
    m_data_re     = 1'b0;
    M_align_err   = 1'b0;
    case (M_memop)
      MEM_SW: begin
        if (M_addr[1:0] == 2'b00) m_data_byteen = BE_WORD;
        else                      M_align_err   = 1'b1;
      end
      MEM_SH: begin
        m_data_wdata = {2{M_wdata[15:0]}};
        if (!M_addr[0]) m_data_byteen = BE_HALF << {M_addr[1], 1'b0};
        else            M_align_err   = 1'b1;
      end
      MEM_SB: begin
        m_data_wdata  = {4{M_wdata[7:0]}};
        m_data_byteen = BE_BYTE << M_addr[1:0];
      end
      MEM_LW: begin
        if (M_addr[1:0] == 2'b00) m_data_re   = 1'b1;
        else                      M_align_err = 1'b1;
      end
      MEM_LH, MEM_LHU: begin
        if (!M_addr[0]) m_data_re   = 1'b1;
        else            M_align_err = 1'b1;
      end
      MEM_LB:  m_data_re = 1'b1;
      default: m_data_re = 1'b0;
    endcase
  end

  always_comb begin
    ctx_d.valid = m_data_re;
    ctx_d.off   = M_addr[1:0];
    ctx_d.op    = mem_op_e'(M_memop);
    ctx_d.sgn   = ~((M_memop == MEM_LHU) | ((M_memop == MEM_LB) & M_lbu));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        ctx_q <= '0;
    else if (!M_hold) ctx_q <= ctx_d;
  end

  assign W_lvalid = ctx_q.valid;

  load_ext u_load_ext (
    .ctx_i   (ctx_q),
    .rdata_i (dm_rdata),
    .ldata_o (W_ldata)
  );

endmodule

// File: tb/tb_mem_data_unit.sv
module tb_mem_data_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] M_addr, M_wdata, dm_rdata;
  logic [2:0]  M_memop;
  logic        M_lbu, M_hold;
  logic [31:0] m_data_addr, m_data_wdata, W_ldata;
  logic [3:0]  m_data_byteen;
  logic        m_data_re, W_lvalid, M_align_err;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mem_data_unit #(.DATA_W(32), .OP_W(3)) dut (
    .clk(clk), .reset(reset),
    .M_addr(M_addr), .M_wdata(M_wdata), .M_memop(M_memop),
    .M_lbu(M_lbu), .M_hold(M_hold),
    .m_data_addr(m_data_addr), .m_data_byteen(m_data_byteen),
    .m_data_wdata(m_data_wdata), .m_data_re(m_data_re),
    .dm_rdata(dm_rdata), .W_ldata(W_ldata), .W_lvalid(W_lvalid),
    .M_align_err(M_align_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [2:0] op, input logic lbu, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic hold);
    M_memop = op; M_lbu = lbu; M_addr = addr; M_wdata = wdata; M_hold = hold;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  // Compare W output against the scoreboard head; pop when the result retires.
  task automatic chk_w(input string tag, input bit pop);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q[0];
      if (pop) void'(exp_q.pop_front());
      chk({tag, "_vld"}, {31'd0, W_lvalid}, 32'd1);
      chk({tag, "_data"}, W_ldata, e);
    end
  endtask

  initial begin
    reset = 1'b1; dm_rdata = '0;
    drv(MEM_NONE, 1'b0, 32'h0, 32'h0, 1'b0);
    #3;
    chk("rst_vld", {31'd0, W_lvalid}, 32'd0);
    chk("rst_data", W_ldata, 32'd0);
    @(negedge clk); reset = 1'b0;

    // Stores: sb at offset 3, sh at offset 2, sw aligned and misaligned
    nxt(); drv(MEM_SB, 1'b0, 32'h0000_0003, 32'h1234_56AB, 1'b0);
    @(negedge clk);
    chk("sb_be", {28'd0, m_data_byteen}, 32'h8);
    chk("sb_wd", m_data_wdata, 32'hABAB_ABAB);
    chk("sb_addr", m_data_addr, 32'h0);
    chk("sb_err", {31'd0, M_align_err}, 32'd0);
    nxt(); drv(MEM_SH, 1'b0, 32'h0000_0106, 32'hCAFE_BEEF, 1'b0);
    @(negedge clk);
    chk("sh_be", {28'd0, m_data_byteen}, 32'hC);
    chk("sh_wd", m_data_wdata, 32'hBEEF_BEEF);
    chk("sh_addr", m_data_addr, 32'h0000_0104);
    nxt(); drv(MEM_SW, 1'b0, 32'h0000_0010, 32'h0BAD_F00D, 1'b0);
    @(negedge clk);
    chk("sw_be", {28'd0, m_data_byteen}, 32'hF);
    chk("sw_wd", m_data_wdata, 32'h0BAD_F00D);
    nxt(); drv(MEM_SW, 1'b0, 32'h0000_0012, 32'h0BAD_F00D, 1'b0);
    @(negedge clk);
    chk("sw_mis_err", {31'd0, M_align_err}, 32'd1);
    chk("sw_mis_be", {28'd0, m_data_byteen}, 32'h0);

    // Misaligned sh, then lw at 0x4 completes normally
    nxt(); drv(MEM_SH, 1'b0, 32'h0000_0001, 32'h1111_2222, 1'b0);
    @(negedge clk);
    chk("shm_err", {31'd0, M_align_err}, 32'd1);
    chk("shm_be", {28'd0, m_data_byteen}, 32'h0);
    chk("shm_re", {31'd0, m_data_re}, 32'd0);
    nxt(); drv(MEM_LW, 1'b0, 32'h0000_0004, 32'h0, 1'b0);
    @(negedge clk);
    chk("lw4_re", {31'd0, m_data_re}, 32'd1);
    chk("lw4_addr", m_data_addr, 32'h4);
    chk("shm_no_ld", {31'd0, W_lvalid}, 32'd0);
    exp_q.push_back(32'hDEAD_BEEF);
    nxt(); drv(MEM_NONE, 1'b0, 32'h0, 32'h0, 1'b0); dm_rdata = 32'hDEAD_BEEF;
    @(negedge clk); chk_w("lw4", 1'b1);

    // Misaligned lw and lh: no read request, no result
    nxt(); drv(MEM_LW, 1'b0, 32'h0000_0006, 32'h0, 1'b0);
    @(negedge clk);
    chk("lwm_err", {31'd0, M_align_err}, 32'd1);
    chk("lwm_re", {31'd0, m_data_re}, 32'd0);
    nxt(); drv(MEM_LH, 1'b0, 32'h0000_0003, 32'h0, 1'b0);
    @(negedge clk);
    chk("lwm_no_ld", {31'd0, W_lvalid}, 32'd0);
    chk("lhm_re", {31'd0, m_data_re}, 32'd0);

    // lb then lbu at offset 2, back-to-back
    nxt(); drv(MEM_LB, 1'b0, 32'h0000_0002, 32'h0, 1'b0);
    @(negedge clk);
    chk("lb_re", {31'd0, m_data_re}, 32'd1);
    exp_q.push_back(32'hFFFF_FF80);
    nxt(); drv(MEM_LB, 1'b1, 32'h0000_0002, 32'h0, 1'b0); dm_rdata = 32'h0080_FF00;
    exp_q.push_back(32'h0000_0080);
    @(negedge clk); chk_w("lb", 1'b1);
    nxt(); drv(MEM_NONE, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk); chk_w("lbu", 1'b1);

    // lh at 0x2 then lhu at 0x0, back-to-back
    nxt(); drv(MEM_LH, 1'b0, 32'h0000_0002, 32'h0, 1'b0);
    exp_q.push_back(32'hFFFF_8001);
    nxt(); drv(MEM_LHU, 1'b0, 32'h0000_0000, 32'h0, 1'b0); dm_rdata = 32'h8001_7FFE;
    exp_q.push_back(32'h0000_7FFE);
    @(negedge clk); chk_w("lh", 1'b1);
    nxt(); drv(MEM_SB, 1'b0, 32'h0000_0001, 32'h0000_0055, 1'b0);
    @(negedge clk); chk_w("lhu", 1'b1);
    chk("st_after_ld_be", {28'd0, m_data_byteen}, 32'h2);

    // lw held for two cycles with another op on the inputs
    nxt(); drv(MEM_LW, 1'b0, 32'h0000_0008, 32'h0, 1'b0);
    exp_q.push_back(32'h1357_2468);
    nxt(); drv(MEM_LH, 1'b0, 32'h0000_0000, 32'h0, 1'b1); dm_rdata = 32'h1357_2468;
    @(negedge clk); chk_w("hold0", 1'b0);
    nxt(); @(negedge clk); chk_w("hold1", 1'b0);
    nxt(); drv(MEM_NONE, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk); chk_w("hold2", 1'b1);
    nxt(); @(negedge clk);
    chk("post_hold_vld", {31'd0, W_lvalid}, 32'd0);

    // lw interrupted by an asynchronous reset mid-cycle
    nxt(); drv(MEM_LW, 1'b0, 32'h0000_000C, 32'h0, 1'b0);
    exp_q.push_back(32'hCAFE_F00D);
    nxt(); drv(MEM_NONE, 1'b0, 32'h0, 32'h0, 1'b0); dm_rdata = 32'hCAFE_F00D;
    #1; chk("pre_rst_vld", {31'd0, W_lvalid}, 32'd1);
    #1; reset = 1'b1;
    #1;
    chk("arst_vld", {31'd0, W_lvalid}, 32'd0);
    chk("arst_data", W_ldata, 32'd0);
    exp_q.delete();
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      nxt(); @(negedge clk);
      chk("post_rst_vld", {31'd0, W_lvalid}, 32'd0);
      chk("post_rst_data", W_ldata, 32'd0);
    end
    nxt(); drv(MEM_LW, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    exp_q.push_back(32'h2468_ACE0);
    nxt(); drv(MEM_NONE, 1'b0, 32'h0, 32'h0, 1'b0); dm_rdata = 32'h2468_ACE0;
    @(negedge clk); chk_w("lw_recover", 1'b1);

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
